// File: rtl/mem_write_checker.sv
// Store-sequence monitor: compares each bus store against a loaded table of expected
// (address, data) pairs in order. Optional per-byte data masking via MWC_BYTE_MASK_EN.
module mem_write_checker #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned IGNORE_ADR = 96
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      exp_load,
  input  logic [ADDR_W-1:0]         exp_adr,
  input  logic [DATA_W-1:0]         exp_data,
`ifdef MWC_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0]       exp_mask,
`endif
  input  logic                      start,
  input  logic                      MemWrite,
  input  logic [ADDR_W-1:0]         DataAdr,
  input  logic [DATA_W-1:0]         WriteData,
  output logic [$clog2(DEPTH):0]    exp_count,
  output logic                      load_ovf,
  output logic                      busy,
  output logic                      pass,
  output logic                      fail,
  output logic                      timed_out,
  output logic [$clog2(DEPTH)-1:0]  fail_idx,
  output logic [ADDR_W-1:0]         fail_adr,
  output logic [DATA_W-1:0]         fail_data
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTout} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       exp_count_q, exp_count_d;
  logic                load_ovf_q, load_ovf_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [IW-1:0]       fail_idx_q, fail_idx_d;
  logic [ADDR_W-1:0]   fail_adr_q, fail_adr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                busy_q, pass_q, fail_q, tout_q;

  logic [ADDR_W-1:0]   tbl_adr_q  [DEPTH];
  logic [DATA_W-1:0]   tbl_data_q [DEPTH];
`ifdef MWC_BYTE_MASK_EN
  logic [NB-1:0]       tbl_mask_q [DEPTH];
`endif
  logic                tbl_we;
  logic [DATA_W-1:0]   cmp_mask;
  logic                adr_hit, data_hit;

  // Table storage needs no reset: exp_count bounds which entries are live.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_adr_q[exp_count_q[IW-1:0]]  <= exp_adr;
      tbl_data_q[exp_count_q[IW-1:0]] <= exp_data;
`ifdef MWC_BYTE_MASK_EN
      tbl_mask_q[exp_count_q[IW-1:0]] <= exp_mask;
`endif
    end
  end

  always_comb begin
    cmp_mask = '1;
`ifdef MWC_BYTE_MASK_EN
    for (int b = 0; b < NB; b++) begin
      cmp_mask[b*8 +: 8] = {8{tbl_mask_q[idx_q][b]}};
    end
`endif
  end

  assign adr_hit  = (DataAdr == tbl_adr_q[idx_q]);
  assign data_hit = (((WriteData ^ tbl_data_q[idx_q]) & cmp_mask) == '0);

  always_comb begin
    state_d     = state_q;
    exp_count_d = exp_count_q;
    load_ovf_d  = load_ovf_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    fail_idx_d  = fail_idx_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    tbl_we      = 1'b0;

    if (clear) begin
      state_d = StIdle;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (exp_load) begin
            if (exp_count_q == CW'(DEPTH)) begin
              load_ovf_d = 1'b1;
            end else begin
              tbl_we      = 1'b1;
              exp_count_d = exp_count_q + CW'(1);
            end
          end
          if (start) begin
            if (exp_count_q != '0) begin
              state_d = StRun;
              idx_d   = '0;
              timer_d = '0;
            end else begin
              state_d = StPass;
            end
          end
        end
        StRun: begin
          // A store to the ignored address behaves like an idle cycle for the timer.
          if (MemWrite && (DataAdr != ADDR_W'(IGNORE_ADR))) begin
            if (adr_hit && data_hit) begin
              idx_d   = idx_q + IW'(1);
              timer_d = '0;
              if (CW'(idx_q) == exp_count_q - CW'(1)) state_d = StPass;
            end else begin
              state_d     = StFail;
              fail_idx_d  = idx_q;
              fail_adr_d  = DataAdr;
              fail_data_d = WriteData;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d    = StTout;
            fail_idx_d = idx_q;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      exp_count_q <= '0;
      load_ovf_q  <= 1'b0;
      idx_q       <= '0;
      timer_q     <= '0;
      fail_idx_q  <= '0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_count_q <= exp_count_d;
      load_ovf_q  <= load_ovf_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      fail_idx_q  <= fail_idx_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      busy_q      <= (state_d == StRun);
      pass_q      <= (state_d == StPass);
      fail_q      <= (state_d == StFail);
      tout_q      <= (state_d == StTout);
    end
  end

  assign exp_count = exp_count_q;
  assign load_ovf  = load_ovf_q;
  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timed_out = tout_q;
  assign fail_idx  = fail_idx_q;
  assign fail_adr  = fail_adr_q;
  assign fail_data = fail_data_q;

endmodule
